// File: rtl/sub_serial.sv
// rtl/sub_serial.sv - multi-cycle borrow-ripple subtractor (a - b - bin)
//
// Purpose:
//   Computes (a - b - bin) mod 2^WIDTH one BITS_PER_CYCLE-wide chunk per clock,
//   LSB first, carrying the borrow between chunks in a register. This uses a
//   short ripple slice in place of a full-width ripple chain, so each result
//   takes N = WIDTH / BITS_PER_CYCLE compute cycles.
//   Optional feature macro: SUB_SIGNED_OVF_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   operation request, accepted only in IDLE or DONE
//   a, b    in   minuend / subtrahend, captured on acceptance
//   bin     in   borrow-in, captured on acceptance
//   busy    out  high while chunks are being computed
//   done    out  one-cycle pulse, results were just updated
//   diff    out  registered result, held between operations
//   bout    out  registered borrow-out (a < b + bin, unsigned)
//   zero    out  registered diff == 0
//   ovf     out  registered signed overflow (SUB_SIGNED_OVF_EN only)
module sub_serial #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  generate
    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("sub_serial: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operand registers shift right each RUN cycle so the active chunk is always
  // at the bottom; the result register fills from the top and is complete
  // after N shifts.
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic [WIDTH-1:0]        r_res;
  logic                    r_br;
  logic [CW-1:0]           r_cnt;

  logic [WIDTH-1:0]        r_diff;
  logic                    r_bout;
  logic                    r_zero;
`ifdef SUB_SIGNED_OVF_EN
  logic                    r_ovf;
`endif

  logic                    w_accept;
  logic                    w_last;
  logic [BITS_PER_CYCLE-1:0] w_x;
  logic [BITS_PER_CYCLE-1:0] w_y;
  logic [BITS_PER_CYCLE-1:0] w_d;
  logic [BITS_PER_CYCLE:0]   w_br;
  logic [WIDTH-1:0]        w_res_nxt;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CHUNK);

  // Borrow-ripple slice: one full subtractor per bit of the chunk.
  always_comb begin
    w_x     = r_a[BITS_PER_CYCLE-1:0];
    w_y     = r_b[BITS_PER_CYCLE-1:0];
    w_d     = '0;
    w_br    = '0;
    w_br[0] = r_br;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_d[i]    = w_x[i] ^ w_y[i] ^ w_br[i];
      w_br[i+1] = (~w_x[i] & w_y[i]) | (~(w_x[i] ^ w_y[i]) & w_br[i]);
    end
  end

  // New chunk enters at the top; earlier chunks move down toward bit 0.
  assign w_res_nxt = (r_res >> BITS_PER_CYCLE) | (WIDTH'(w_d) << (WIDTH - BITS_PER_CYCLE));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> BITS_PER_CYCLE;
      r_b   <= r_b >> BITS_PER_CYCLE;
      r_br  <= w_br[BITS_PER_CYCLE];
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res_nxt;
        r_bout <= w_br[BITS_PER_CYCLE];
        r_zero <= (w_res_nxt == '0);
`ifdef SUB_SIGNED_OVF_EN
        // Borrow into the MSB differs from borrow out of it exactly when
        // the signed result leaves the representable range.
        r_ovf  <= w_br[BITS_PER_CYCLE-1] ^ w_br[BITS_PER_CYCLE];
`endif
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// tb/tb_sub_serial.sv - self-checking bench for sub_serial (8/1 and 16/4 instances)
module tb_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        s8_start, s8_bin;
  logic [7:0]  s8_a, s8_b;
  logic        d8_busy, d8_done, d8_bout, d8_zero, d8_ovf;
  logic [7:0]  d8_diff;

  logic        s16_start, s16_bin;
  logic [15:0] s16_a, s16_b;
  logic        d16_busy, d16_done, d16_bout, d16_zero, d16_ovf;
  logic [15:0] d16_diff;

  int n_vec = 0;
  int n_err = 0;

  sub_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s8_start),
    .a     (s8_a),
    .b     (s8_b),
    .bin   (s8_bin),
    .busy  (d8_busy),
    .done  (d8_done),
    .diff  (d8_diff),
    .bout  (d8_bout),
    .zero  (d8_zero)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (d8_ovf)
`endif
  );

  sub_serial #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s16_start),
    .a     (s16_a),
    .b     (s16_b),
    .bin   (s16_bin),
    .busy  (d16_busy),
    .done  (d16_done),
    .diff  (d16_diff),
    .bout  (d16_bout),
    .zero  (d16_zero)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (d16_ovf)
`endif
  );

`ifndef SUB_SIGNED_OVF_EN
  assign d8_ovf  = 1'b0;
  assign d16_ovf = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the captured operands.
  task automatic check_result(input string tag, input int w,
                              input logic [15:0] ta, input logic [15:0] tbv, input logic tbin);
    longint full, mask, exp_diff;
    logic [15:0] o_diff;
    logic o_bout, o_zero;
`ifdef SUB_SIGNED_OVF_EN
    longint half, sa, sb, sres;
    logic o_ovf;
`endif
    mask     = (longint'(1) << w) - 1;
    full     = longint'(ta) - longint'(tbv) - longint'(tbin);
    exp_diff = full & mask;
    if (w == 8) begin
      o_diff = {8'h00, d8_diff};
      o_bout = d8_bout;
      o_zero = d8_zero;
    end else begin
      o_diff = d16_diff;
      o_bout = d16_bout;
      o_zero = d16_zero;
    end
    check({tag, "_diff"}, 64'(o_diff), 64'(exp_diff));
    check({tag, "_bout"}, 64'(o_bout), 64'(full < 0));
    check({tag, "_zero"}, 64'(o_zero), 64'(exp_diff == 0));
`ifdef SUB_SIGNED_OVF_EN
    half  = longint'(1) << (w - 1);
    sa    = (longint'(ta) >= half) ? longint'(ta) - 2 * half : longint'(ta);
    sb    = (longint'(tbv) >= half) ? longint'(tbv) - 2 * half : longint'(tbv);
    sres  = sa - sb - longint'(tbin);
    o_ovf = (w == 8) ? d8_ovf : d16_ovf;
    check({tag, "_ovf"}, 64'(o_ovf), 64'((sres < -half) || (sres >= half)));
`endif
  endtask

  // Presents one request; returns just after the accepting edge (cycle 1 starts).
  task automatic launch(input int w, input logic [15:0] ta, input logic [15:0] tbv, input logic tbin);
    @(negedge clk);
    if (w == 8) begin
      s8_a = ta[7:0]; s8_b = tbv[7:0]; s8_bin = tbin; s8_start = 1'b1;
    end else begin
      s16_a = ta; s16_b = tbv; s16_bin = tbin; s16_start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (w == 8) s8_start = 1'b0;
    else        s16_start = 1'b0;
  endtask

  // Counts cycles until done (bounded), scrambling operands meanwhile.
  task automatic wait_done(input int w, output int cyc, output logic [63:0] bmask);
    cyc   = 0;
    bmask = '0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (w == 8) begin
        if (d8_busy) bmask[cyc] = 1'b1;
        if (d8_done) break;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_bin = 1'($urandom);
      end else begin
        if (d16_busy) bmask[cyc] = 1'b1;
        if (d16_done) break;
        s16_a = 16'($urandom); s16_b = 16'($urandom); s16_bin = 1'($urandom);
      end
    end
  endtask

  task automatic run_op(input string tag, input int w,
                        input logic [15:0] ta, input logic [15:0] tbv, input logic tbin);
    int cyc;
    logic [63:0] bmask;
    int n;
    n = (w == 8) ? 8 : 4;
    launch(w, ta, tbv, tbin);
    wait_done(w, cyc, bmask);
    check({tag, "_lat"}, 64'(cyc), 64'(n + 1));
    check_result(tag, w, ta, tbv, tbin);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int bad;
    logic [63:0] bmask;
    logic [7:0] ra, rb;
    logic rbin;
    logic [15:0] wa, wb;
    logic wbin;

    rst_n = 1'b0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0; s8_bin = 1'b0;
    s16_start = 1'b0; s16_a = '0; s16_b = '0; s16_bin = 1'b0;

    // 1: reset values, then idle with start low
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(d8_busy), 64'(0));
    check("rst_done", 64'(d8_done), 64'(0));
    check("rst_diff", 64'(d8_diff), 64'(0));
    check("rst_bout", 64'(d8_bout), 64'(0));
    check("rst_zero", 64'(d8_zero), 64'(0));
    check("rst_ovf",  64'(d8_ovf),  64'(0));
    check("rst16_diff", 64'(d16_diff), 64'(0));
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d8_busy || d8_done || d16_busy || d16_done) bad++;
    end
    check("idle_quiet", 64'(bad), 64'(0));

    // 2: borrow wrap with exact busy window
    launch(8, 16'h00, 16'h01, 1'b0);
    wait_done(8, cyc, bmask);
    check("wrap_lat", 64'(cyc), 64'(9));
    check("wrap_busy", bmask, 64'h1FE);
    check("wrap_done", 64'(d8_done), 64'(1));
    check_result("wrap", 8, 16'h00, 16'h01, 1'b0);

    // 3: zero result via borrow-in, then hold while operands wander
    run_op("zero", 8, 16'h5A, 16'h59, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_bin = 1'($urandom);
      check("hold_done", 64'(d8_done), 64'(0));
      check_result("hold", 8, 16'h5A, 16'h59, 1'b1);
    end

    // 4: start ignored mid-run, then back-to-back from DONE
    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    launch(8, {8'h00, ra}, {8'h00, rb}, rbin);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) begin
        s8_start = 1'b1; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_bin = 1'($urandom);
      end
      if (c == 5) s8_start = 1'b0;
      if (c == 8) begin
        s8_a = 8'h10; s8_b = 8'h20; s8_bin = 1'b0; s8_start = 1'b1;
      end
    end
    @(negedge clk);
    check("ign_done", 64'(d8_done), 64'(1));
    check_result("ign", 8, {8'h00, ra}, {8'h00, rb}, rbin);
    @(posedge clk);
    #1;
    s8_start = 1'b0;
    wait_done(8, cyc, bmask);
    check("b2b_lat", 64'(cyc), 64'(9));
    check_result("b2b", 8, 16'h10, 16'h20, 1'b0);

    // 5: reset in the middle of a run
    launch(8, 16'h33, 16'h11, 1'b0);
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(d8_busy), 64'(0));
    check("mid_rst_done", 64'(d8_done), 64'(0));
    check("mid_rst_diff", 64'(d8_diff), 64'(0));
    check("mid_rst_bout", 64'(d8_bout), 64'(0));
    rst_n = 1'b1;
    run_op("post_rst", 8, 16'h80, 16'h01, 1'b0);

    // 8-bit random sweep with corner operands first
    run_op("c8a", 8, 16'hFF, 16'hFF, 1'b1);
    run_op("c8b", 8, 16'h7F, 16'hFF, 1'b0);
    run_op("c8c", 8, 16'h00, 16'h00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      run_op("r8", 8, {8'h00, 8'($urandom)}, {8'h00, 8'($urandom)}, 1'($urandom));
    end

    // 6: 16-bit, 4 bits per cycle
    launch(16, 16'h1234, 16'h0234, 1'b0);
    wait_done(16, cyc, bmask);
    check("w16_lat", 64'(cyc), 64'(5));
    check("w16_busy", bmask, 64'h1E);
    check_result("w16", 16, 16'h1234, 16'h0234, 1'b0);
    run_op("c16a", 16, 16'h0000, 16'hFFFF, 1'b1);
    run_op("c16b", 16, 16'h8000, 16'h0001, 1'b0);
    run_op("c16c", 16, 16'h7FFF, 16'hFFFF, 1'b0);
    run_op("c16d", 16, 16'hABCD, 16'hABCC, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom); wb = 16'($urandom); wbin = 1'($urandom);
      run_op("r16", 16, wa, wb, wbin);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
